// File: rtl/rr_arb_mux.sv
// N-to-1 channel mux with direct-select or round-robin grant, feeding a
// single-entry output register with valid/ready handshakes on both sides.
module rr_arb_mux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  localparam int unsigned PadW = 2 ** SEL_W;

  logic [SEL_W-1:0] ptr_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_chan_q;

  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load_en;
  logic             in_xfer;
  logic [PadW-1:0]  valid_pad;
  logic [PadW-1:0]  ready_pad;
  logic [WIDTH-1:0] grant_data;

  // Padding to the full select range lets out-of-range sel read as "not valid".
  always_comb begin : grant_search
    int unsigned idx;
    valid_pad                 = '0;
    valid_pad[CHANNELS-1:0]   = in_valid;
    grant                     = '0;
    grant_valid               = 1'b0;
    idx                       = 0;
    if (!mode) begin
      if ((32'(sel) < CHANNELS) && valid_pad[sel]) begin
        grant       = sel;
        grant_valid = 1'b1;
      end
    end else begin
      // Search starts just after the last granted channel; ptr itself is last.
      for (int unsigned i = 1; i <= CHANNELS; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!grant_valid && valid_pad[idx[SEL_W-1:0]]) begin
          grant       = idx[SEL_W-1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load_en          = !out_valid_q || out_ready;
    ready_pad        = '0;
    ready_pad[grant] = load_en && grant_valid && !reset;
    in_ready         = ready_pad[CHANNELS-1:0];
    in_xfer          = |in_ready;
    grant_data       = in_data[32'(grant)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_chan_q  <= grant;
      ptr_q       <= grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
